// File: rtl/pipeline_hazard_controller.sv
// Hazard, forwarding and stall sequencer for a 5-stage MIPS pipeline.
// Keeps its own EX/MEM record of in-flight writers and a countdown for the iterative mul/div unit.
module pipeline_hazard_controller #(
   parameter int MULDIV_CYCLES = 32,
   parameter int COUNTER_WIDTH = 6
) (
   input  logic       clock,
   input  logic       resetN,
   input  logic       idValid,
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   input  logic       idUsesRs,
   input  logic       idUsesRt,
   input  logic       idWritesReg,
   input  logic [4:0] idDestR,
   input  logic       idIsLoad,
   input  logic       idIsMulDiv,
   input  logic       exBranchTaken,
   output logic       pcWriteEnable,
   output logic       ifIdWriteEnable,
   output logic       ifIdFlush,
   output logic       idExBubble,
   output logic [1:0] exForwardRs,
   output logic [1:0] exForwardRt,
   output logic       exMulDivStart,
   output logic       mulDivBusy
);

   typedef struct packed {
      logic       valid;
      logic       writesReg;
      logic [4:0] destR;
      logic       isLoad;
   } slot_t;

   // The WB stage is not recorded: anything there is written back before ID needs it
   // (write-through register file), so only EX and MEM producers can create hazards.
   slot_t                    exSlot_q, exSlot_d;
   slot_t                    memSlot_q;
   logic [1:0]               fwdRs_q, fwdRs_d;
   logic [1:0]               fwdRt_q, fwdRt_d;
   logic                     start_q, start_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;

   logic exRsMatch, exRtMatch, memRsMatch, memRtMatch;
   logic loadStall, busyStall, stall, accepted;

   function automatic logic slotMatch(slot_t s, logic [4:0] r, logic uses);
      return uses & s.valid & s.writesReg & (s.destR == r) & (r != 5'd0);
   endfunction

   assign exRsMatch  = slotMatch(exSlot_q, idRs, idUsesRs);
   assign exRtMatch  = slotMatch(exSlot_q, idRt, idUsesRt);
   assign memRsMatch = slotMatch(memSlot_q, idRs, idUsesRs);
   assign memRtMatch = slotMatch(memSlot_q, idRt, idUsesRt);

   assign busyStall = (count_q != '0);
   assign loadStall = idValid & exSlot_q.isLoad & (exRsMatch | exRtMatch);
   assign stall     = loadStall | busyStall;
   assign accepted  = idValid & ~stall & ~exBranchTaken;

   // Redirect beats stall: the instruction being held is on the wrong path anyway.
   always_comb begin
      pcWriteEnable   = 1'b1;
      ifIdWriteEnable = 1'b1;
      ifIdFlush       = 1'b0;
      idExBubble      = 1'b0;
      if (exBranchTaken) begin
         ifIdFlush  = 1'b1;
         idExBubble = 1'b1;
      end else if (stall) begin
         pcWriteEnable   = 1'b0;
         ifIdWriteEnable = 1'b0;
         idExBubble      = 1'b1;
      end
   end

   always_comb begin
      fwdRs_d  = 2'd0;
      fwdRt_d  = 2'd0;
      start_d  = 1'b0;
      exSlot_d = '0;
      count_d  = count_q;
      if (accepted) begin
         if (exRsMatch && !exSlot_q.isLoad) fwdRs_d = 2'd1;
         else if (memRsMatch)               fwdRs_d = 2'd2;
         if (exRtMatch && !exSlot_q.isLoad) fwdRt_d = 2'd1;
         else if (memRtMatch)               fwdRt_d = 2'd2;
         start_d  = idIsMulDiv;
         exSlot_d = '{valid: 1'b1, writesReg: idWritesReg, destR: idDestR, isLoad: idIsLoad};
      end
      if (accepted && idIsMulDiv)
         count_d = COUNTER_WIDTH'(MULDIV_CYCLES - 1);
      else if (count_q != '0)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         exSlot_q  <= '0;
         memSlot_q <= '0;
         fwdRs_q   <= 2'd0;
         fwdRt_q   <= 2'd0;
         start_q   <= 1'b0;
         count_q   <= '0;
      end else begin
         exSlot_q  <= exSlot_d;
         memSlot_q <= exSlot_q;
         fwdRs_q   <= fwdRs_d;
         fwdRt_q   <= fwdRt_d;
         start_q   <= start_d;
         count_q   <= count_d;
      end
   end

   assign exForwardRs   = fwdRs_q;
   assign exForwardRt   = fwdRt_q;
   assign exMulDivStart = start_q;
   assign mulDivBusy    = busyStall;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: the driver queues hand-computed
// expectations per cycle, a monitor pops and compares them at each falling edge.
module tb_pipeline_hazard_controller;

   logic       clock = 1'b0;
   logic       resetN;
   logic       idValid, idUsesRs, idUsesRt, idWritesReg, idIsLoad, idIsMulDiv, exBranchTaken;
   logic [4:0] idRs, idRt, idDestR;
   logic       pcWriteEnable, ifIdWriteEnable, ifIdFlush, idExBubble, exMulDivStart, mulDivBusy;
   logic [1:0] exForwardRs, exForwardRt;

   int assertCount = 0;
   int failCount   = 0;

   typedef struct {
      logic       valid;
      logic [4:0] rs, rt;
      logic       usesRs, usesRt, writes;
      logic [4:0] dest;
      logic       isLoad, isMd;
   } instr_t;

   typedef struct {
      string      name;
      logic [3:0] ctl;
      logic [1:0] fRs, fRt;
      logic       start, busy;
   } exp_t;

   localparam logic [3:0] CTL_N     = 4'b1100;
   localparam logic [3:0] CTL_STALL = 4'b0001;
   localparam logic [3:0] CTL_FLUSH = 4'b1111;

   exp_t expQ[$];
   event checkEv;

   pipeline_hazard_controller #(.MULDIV_CYCLES(4), .COUNTER_WIDTH(3)) dut (
      .clock(clock), .resetN(resetN), .idValid(idValid), .idRs(idRs), .idRt(idRt),
      .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idWritesReg(idWritesReg), .idDestR(idDestR),
      .idIsLoad(idIsLoad), .idIsMulDiv(idIsMulDiv), .exBranchTaken(exBranchTaken),
      .pcWriteEnable(pcWriteEnable), .ifIdWriteEnable(ifIdWriteEnable), .ifIdFlush(ifIdFlush),
      .idExBubble(idExBubble), .exForwardRs(exForwardRs), .exForwardRt(exForwardRt),
      .exMulDivStart(exMulDivStart), .mulDivBusy(mulDivBusy)
   );

   always #5 clock = ~clock;

   function automatic instr_t idle();
      instr_t i = '{default: '0};
      return i;
   endfunction

   function automatic instr_t alu(logic [4:0] d, logic [4:0] s, logic [4:0] t);
      instr_t i = '{valid: 1'b1, rs: s, rt: t, usesRs: 1'b1, usesRt: 1'b1, writes: 1'b1,
                    dest: d, isLoad: 1'b0, isMd: 1'b0};
      return i;
   endfunction

   function automatic instr_t lw(logic [4:0] d, logic [4:0] base);
      instr_t i = alu(d, base, d);
      i.usesRt = 1'b0;
      i.isLoad = 1'b1;
      return i;
   endfunction

   function automatic instr_t mult(logic [4:0] s, logic [4:0] t);
      instr_t i = alu(5'd0, s, t);
      i.writes = 1'b0;
      i.isMd   = 1'b1;
      return i;
   endfunction

   function automatic exp_t expOut(string n, logic [3:0] c, logic [1:0] r, logic [1:0] t,
                                   logic st, logic b);
      exp_t e = '{name: n, ctl: c, fRs: r, fRt: t, start: st, busy: b};
      return e;
   endfunction

   // One clock of stimulus; the matching expectation goes to the scoreboard queue.
   task automatic applyStimulus(instr_t i, logic br, exp_t e);
      @(posedge clock);
      #1;
      idValid = i.valid; idRs = i.rs; idRt = i.rt; idUsesRs = i.usesRs; idUsesRt = i.usesRt;
      idWritesReg = i.writes; idDestR = i.dest; idIsLoad = i.isLoad; idIsMulDiv = i.isMd;
      exBranchTaken = br;
      expQ.push_back(e);
   endtask

   // Pull reset low between edges and check that state clears without a clock.
   task automatic asyncResetCheck(string n);
      @(negedge clock);
      #2;
      resetN = 1'b0;
      #1;
      expQ.push_back(expOut(n, CTL_N, 2'd0, 2'd0, 1'b0, 1'b0));
      -> checkEv;
      #1;
      resetN = 1'b1;
   endtask

   task automatic checkOutput(string n, string field, int actual, int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", n, field, actual, expected);
      end
   endtask

   // Monitor: compares whatever expectation is pending whenever outputs are sampled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock or checkEv);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "pcWriteEnable",   int'(pcWriteEnable),   int'(e.ctl[3]));
            checkOutput(e.name, "ifIdWriteEnable", int'(ifIdWriteEnable), int'(e.ctl[2]));
            checkOutput(e.name, "ifIdFlush",       int'(ifIdFlush),       int'(e.ctl[1]));
            checkOutput(e.name, "idExBubble",      int'(idExBubble),      int'(e.ctl[0]));
            checkOutput(e.name, "exForwardRs",     int'(exForwardRs),     int'(e.fRs));
            checkOutput(e.name, "exForwardRt",     int'(exForwardRt),     int'(e.fRt));
            checkOutput(e.name, "exMulDivStart",   int'(exMulDivStart),   int'(e.start));
            checkOutput(e.name, "mulDivBusy",      int'(mulDivBusy),      int'(e.busy));
         end
      end
   end

   initial begin
      instr_t i;
      int waitCycles;
      resetN = 1'b0;
      idValid = 1'b0; idRs = '0; idRt = '0; idUsesRs = 1'b0; idUsesRt = 1'b0;
      idWritesReg = 1'b0; idDestR = '0; idIsLoad = 1'b0; idIsMulDiv = 1'b0; exBranchTaken = 1'b0;
      #12;
      resetN = 1'b1;

      applyStimulus(idle(), 1'b0, expOut("reset", CTL_N, 0, 0, 0, 0));

      // Back-to-back dependency forwarded from MEM
      applyStimulus(alu(3, 1, 2), 1'b0, expOut("t1_add", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(4, 3, 5), 1'b0, expOut("t1_sub", CTL_N, 0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("t1_fwd", CTL_N, 1, 0, 0, 0));

      // One instruction gap forwards from WB; register 0 never forwards
      applyStimulus(alu(3, 1, 2), 1'b0, expOut("t2_add", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(7, 8, 9), 1'b0, expOut("t2_and", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(6, 3, 0), 1'b0, expOut("t2_or",  CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(0, 1, 2), 1'b0, expOut("t2_fwd", CTL_N, 2, 0, 0, 0));
      applyStimulus(alu(5, 0, 0), 1'b0, expOut("t2_wr0", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(8, 1, 2), 1'b0, expOut("t2_rd0", CTL_N, 0, 0, 0, 0));

      // Newest producer wins; unused rt operand is not forwarded
      applyStimulus(alu(8, 3, 4), 1'b0, expOut("nw_a", CTL_N, 0, 0, 0, 0));
      i = alu(9, 8, 8);
      i.usesRt = 1'b0;
      applyStimulus(i,            1'b0, expOut("nw_b", CTL_N, 0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("nw_fwd", CTL_N, 1, 0, 0, 0));

      // Load-use: one stall cycle then WB forwarding on both operands
      applyStimulus(lw(2, 1),     1'b0, expOut("t3_lw",    CTL_N,     0, 0, 0, 0));
      applyStimulus(alu(4, 2, 2), 1'b0, expOut("t3_stall", CTL_STALL, 0, 0, 0, 0));
      applyStimulus(alu(4, 2, 2), 1'b0, expOut("t3_retry", CTL_N,     0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("t3_fwd",   CTL_N,     2, 2, 0, 0));

      // Multiply occupies the unit for 3 further cycles, holding ID
      applyStimulus(mult(1, 2),   1'b0, expOut("t4_mult",  CTL_N,     0, 0, 0, 0));
      applyStimulus(alu(5, 6, 7), 1'b0, expOut("t4_busy3", CTL_STALL, 0, 0, 1, 1));
      applyStimulus(alu(5, 6, 7), 1'b0, expOut("t4_busy2", CTL_STALL, 0, 0, 0, 1));
      applyStimulus(alu(5, 6, 7), 1'b0, expOut("t4_busy1", CTL_STALL, 0, 0, 0, 1));
      applyStimulus(alu(5, 6, 7), 1'b0, expOut("t4_go",    CTL_N,     0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("t4_done",  CTL_N,     0, 0, 0, 0));

      // Branch coinciding with a load-use stall: redirect wins, consumer dropped
      applyStimulus(lw(2, 1),     1'b0, expOut("t5_lw",    CTL_N,     0, 0, 0, 0));
      applyStimulus(alu(4, 2, 2), 1'b1, expOut("t5_flush", CTL_FLUSH, 0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("t5_after", CTL_N,     0, 0, 0, 0));

      // Branch does not cancel a mul/div; busy stalls even with ID empty; reset at countdown 2
      applyStimulus(mult(1, 2),   1'b0, expOut("t6_mult",  CTL_N,     0, 0, 0, 0));
      applyStimulus(idle(),       1'b1, expOut("t6_br",    CTL_FLUSH, 0, 0, 1, 1));
      applyStimulus(idle(),       1'b0, expOut("t6_cnt2",  CTL_STALL, 0, 0, 0, 1));
      asyncResetCheck("t6_rstBusy");
      applyStimulus(idle(),       1'b0, expOut("t6_post",  CTL_N,     0, 0, 0, 0));

      // Reset while forwards are live; first post-reset instruction sees an empty scoreboard
      applyStimulus(alu(3, 1, 2), 1'b0, expOut("r_add", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(4, 3, 3), 1'b0, expOut("r_sub", CTL_N, 0, 0, 0, 0));
      applyStimulus(alu(5, 4, 4), 1'b0, expOut("r_fwd", CTL_N, 1, 1, 0, 0));
      asyncResetCheck("r_rstFwd");
      applyStimulus(alu(6, 5, 5), 1'b0, expOut("r_first", CTL_N, 0, 0, 0, 0));
      applyStimulus(idle(),       1'b0, expOut("r_fwd2",  CTL_N, 1, 1, 0, 0));

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(posedge clock);
         waitCycles++;
      end
      if (expQ.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
